ktwt_sched: RTL
===============

# ktwt_sched

Parametrised, registered Kt+Wt generator for the SHA-256 round datapath of one miner core, serving `LANES` independent nonce lanes. It folds compile-time constants for the padding-only rounds of pass-1 and pass-2, and caches the nonce-invariant rounds 16/17. It also caches the nonce-linear round-19 sum per lane and advances that sum by `NONCE_STEP` on each nonce advance instead of recomputing it. It sits between the W-schedule/K-ROM and the compression-round adder tree.

## Interface
- `CORE`, default 0: core index, for debug tagging only; no functional effect.
- `LANES`, default 4: number of nonce lanes, 1..16.
- `NONCE_STEP`, default 32'd1: amount added to a lane's cached round-19 sum per nonce advance.
- `LW`, default `$clog2(LANES)` (min 1): lane index width.

Ports:
- `clk`  in  1  clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  block enable; when low, outputs hold and `out_valid`=0.
- `flush`  in  1  new job/midstate; invalidates all caches.
- `mode`  in  2  0 = plain, 1 = pass-1 (header block 2), 2 = pass-2 (hash of hash), 3 = plain.
- `in_valid`  in  1  request valid this cycle.
- `lane_sel`  in  LW  lane of the request.
- `r_cntr`  in  6  round index 0..63.
- `kt`  in  32  round constant.
- `wt`  in  32  schedule word.
- `nonce_adv`  in  LANES  per-lane pulse: advance that lane's nonce.
- `out_valid`  out  1  `ktwt` valid.
- `ktwt`  out  32  Kt+Wt result.
- `lane_warm`  out  LANES  lane cache fully captured.

## Operation
- All sums are 32-bit modulo 2^32; carries are discarded.
- Mode 0/3: `ktwt` = `kt`+`wt`.
- Mode 2:
  - r=8 → 32'h5807aa98.
  - r=9..14 → `kt`.
  - r=15 → 32'hc19bf274.
  - otherwise `kt`+`wt`.
- Mode 1, fixed constants:
  - r=4 → 32'hb956c25b.
  - r=5..14 → `kt`.
  - r=15 → 32'hc19bf3f4.
- Mode 1, shared cache for r=16/17 (flags `c16`, `c17`, values `r16`, `r17`):
  - Flag clear: output `wt`+K16 (32'he49b69c1) or `wt`+K17 (32'hefbe4786), store it, set the flag.
  - Flag set: output the stored value; `wt` is ignored.
- Mode 1, per-lane cache for r=19:
  - Lane state COLD: output `wt`+32'h240ca1cc, store it in `r19[lane]`, lane → WARM.
  - Lane state WARM: output `r19[lane]`.
- Mode 1, all other rounds: `kt`+`wt`.
- `lane_warm[i]` = (lane i WARM) & `c16` & `c17`.
- Per-lane FSM:
  - COLD → WARM on a mode-1 r=19 request for that lane.
  - WARM → COLD on `flush`.
  - No other transitions.
- `nonce_adv[i]`: `r19[i]` += `NONCE_STEP` if lane i is WARM; ignored in COLD.
- Boundary rules:
  - `flush` with `in_valid` in the same cycle: flush wins. The request is computed as cold and nothing is stored; all flags and lane states clear.
  - `nonce_adv[i]` with a WARM r=19 read of lane i: output the pre-increment value; the register takes the incremented value.
  - `nonce_adv[i]` with a COLD capture of lane i: store captured value + `NONCE_STEP`; lane → WARM.
  - `r19` wraps 32'hffffffff + 1 → 0.
  - `en`=0: requests, `nonce_adv` and `flush` are ignored; all state holds.
  - Mid-operation `rst`: all state clears immediately, regardless of clock.

## Timing
- Latency: one cycle, fully pipelined, one request per cycle. `out_valid`(t+1) = `in_valid`(t) & `en`(t).
- `ktwt` holds its last value when `out_valid`=0.
- Reset values:
  - `ktwt`=0, `out_valid`=0, `lane_warm`=0.
  - `c16`=`c17`=0, all `r16`/`r17`/`r19`=0.
  - All lanes COLD.
- Cache writes land at the same edge as the output register; a request in the following cycle sees the new value.

## Configuration
- `KTWT_R19_INC_EN` defined:
  - Per-lane r=19 caching, `nonce_adv` increment and the round-19 part of `lane_warm` as above.
- `KTWT_R19_INC_EN` undefined:
  - r=19 always outputs `kt`+`wt`.
  - `r19` registers and lane FSMs are not built.
  - `nonce_adv` is ignored.
  - `lane_warm[i]` = `c16` & `c17` for all i.

## Structure
- Package `ktwt_pkg`:
  - folded constants (4 of them), K16, K17, K19;
  - `mode_e` enum;
  - `lane_st_e` enum {COLD, WARM}.
- Sub-module `ktwt_lane_cache`, one instance per lane under `generate`: lane FSM, `r19` register, increment adder.
- Top level holds the mode/round decode, the shared r16/r17 cache and the output register.

## Test plan
- Mode 1, r=4, `wt`=random → `ktwt`=32'hb956c25b one cycle later; r=9 with `kt`=32'h12835b01 → 32'h12835b01.
- Mode 1, r=16 `wt`=32'h11111111 → 32'hf5ac7ad2. Then r=16 `wt`=0 → 32'hf5ac7ad2 (cached).
- Lane 0, r=19 `wt`=32'h10 → 32'h240ca1dc. Pulse `nonce_adv[0]`, then r=19 → 32'h240ca1dd. Lane 1 is still COLD.
- Force `r19[2]`=32'hffffffff via capture, then `nonce_adv[2]` → next read 32'h00000000. Same-cycle read+adv returns 32'hffffffff.
- `flush` with a mode-1 r=16 request → output = `wt`+32'he49b69c1, `c16` stays 0, `lane_warm`=0.
- Assert `rst` between clock edges while WARM → all outputs 0 immediately; a subsequent r=19 request recaptures.

Source files
------------

// File: rtl/ktwt_pkg.sv
// ktwt_pkg: shared constants and enums for the Kt+Wt round-word generator.
// Folded values cover the padding-only rounds of pass-1 and pass-2; K16/K17/K19
// are the round constants pre-added into the cached rounds.
package ktwt_pkg;

    // Pass-1 (header block 2) folded Kt+Wt values
    localparam logic [31:0] P1_R4_C  = 32'hb956c25b;
    localparam logic [31:0] P1_R15_C = 32'hc19bf3f4;
    // Pass-2 (hash of hash) folded Kt+Wt values
    localparam logic [31:0] P2_R8_C  = 32'h5807aa98;
    localparam logic [31:0] P2_R15_C = 32'hc19bf274;

    // Round constants added to the schedule word of the cached rounds
    localparam logic [31:0] K16 = 32'he49b69c1;
    localparam logic [31:0] K17 = 32'hefbe4786;
    localparam logic [31:0] K19 = 32'h240ca1cc;

    typedef enum logic [1:0] {
        MODE_PLAIN0 = 2'd0,
        MODE_PASS1  = 2'd1,
        MODE_PASS2  = 2'd2,
        MODE_PLAIN3 = 2'd3
    } mode_e;

    typedef enum logic {
        COLD = 1'b0,
        WARM = 1'b1
    } lane_st_e;

endpackage

// File: rtl/ktwt_lane_cache.sv
// ktwt_lane_cache: one nonce lane's round-19 cache (COLD/WARM state plus the
// cached Kt+Wt sum). Instantiated by ktwt_sched only when KTWT_R19_INC_EN is
// defined. A nonce advance bumps the cached sum by NONCE_STEP instead of
// recomputing round 19 from the schedule.
module ktwt_lane_cache #(
    parameter logic [31:0] NONCE_STEP = 32'd1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en_i,
    input  logic        flush_i,
    input  logic        cap_i,
    input  logic        adv_i,
    input  logic [31:0] cap_val_i,
    output logic        warm_o,
    output logic [31:0] r19_o
);
    import ktwt_pkg::*;

    lane_st_e    st_q, st_d;
    logic [31:0] r19_q, r19_d;

    // Next state: flush beats capture; a capture that coincides with an advance
    // stores the already-advanced value so the next read is correct.
    always_comb begin
        st_d  = st_q;
        r19_d = r19_q;
        if (en_i) begin
            if (flush_i) begin
                st_d = COLD;
            end else if (st_q == COLD) begin
                if (cap_i) begin
                    st_d  = WARM;
                    r19_d = cap_val_i + (adv_i ? NONCE_STEP : 32'd0);
                end
            end else if (adv_i) begin
                r19_d = r19_q + NONCE_STEP;
            end
        end
    end

    // Lane state and cached sum registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q  <= COLD;
            r19_q <= 32'd0;
        end else begin
            st_q  <= st_d;
            r19_q <= r19_d;
        end
    end

    assign warm_o = (st_q == WARM);
    assign r19_o  = r19_q;

endmodule

// File: rtl/ktwt_sched.sv
// ktwt_sched: registered Kt+Wt generator for one miner core's round datapath.
// Folds constant rounds for pass-1/pass-2, caches the nonce-invariant rounds
// 16/17 and, when KTWT_R19_INC_EN is defined, keeps a per-lane round-19 sum
// that is advanced by NONCE_STEP on each nonce advance.
// CORE is a debug tag only.
module ktwt_sched #(
    parameter int          CORE       = 0,
    parameter int          LANES      = 4,
    parameter logic [31:0] NONCE_STEP = 32'd1,
    parameter int          LW         = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             flush,
    input  logic [1:0]       mode,
    input  logic             in_valid,
    input  logic [LW-1:0]    lane_sel,
    input  logic [5:0]       r_cntr,
    input  logic [31:0]      kt,
    input  logic [31:0]      wt,
    input  logic [LANES-1:0] nonce_adv,
    output logic             out_valid,
    output logic [31:0]      ktwt,
    output logic [LANES-1:0] lane_warm
);
    import ktwt_pkg::*;

    localparam int unused_core_tag = CORE;

    mode_e       mode_s;
    logic        req;
    logic        flush_acc;
    logic        c16_q, c16_d, c17_q, c17_d;
    logic [31:0] r16_q, r16_d, r17_q, r17_d;
    logic [31:0] res_d;
    logic [31:0] ktwt_q;
    logic        out_valid_q;

    assign mode_s    = mode_e'(mode);
    assign req       = en & in_valid;
    assign flush_acc = en & flush;

`ifdef KTWT_R19_INC_EN
    logic [LANES-1:0] warm_s;
    logic [31:0]      r19_s [LANES];
    logic             sel_warm;
    logic [31:0]      sel_r19;
    logic             is_r19_p1;

    assign is_r19_p1 = (mode_s == MODE_PASS1) && (r_cntr == 6'd19);

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            ktwt_lane_cache #(.NONCE_STEP(NONCE_STEP)) u_lane (
                .clk       (clk),
                .rst       (rst),
                .en_i      (en),
                .flush_i   (flush),
                .cap_i     (req & is_r19_p1 & (lane_sel == LW'(gi))),
                .adv_i     (nonce_adv[gi]),
                .cap_val_i (wt + K19),
                .warm_o    (warm_s[gi]),
                .r19_o     (r19_s[gi])
            );
        end
    endgenerate

    // Select the requested lane's cache; out-of-range lanes read as COLD
    always_comb begin
        sel_warm = 1'b0;
        sel_r19  = 32'd0;
        for (int i = 0; i < LANES; i++) begin
            if (lane_sel == LW'(i)) begin
                sel_warm = warm_s[i];
                sel_r19  = r19_s[i];
            end
        end
    end

    assign lane_warm = warm_s & {LANES{c16_q & c17_q}};
`else
    logic unused_r19_inputs;
    assign unused_r19_inputs = ^{nonce_adv, lane_sel};
    assign lane_warm = {LANES{c16_q & c17_q}};
`endif

    // Round decode and shared r16/r17 cache update; a flush forces a cold
    // computation and suppresses every store
    always_comb begin
        res_d = kt + wt;
        c16_d = c16_q;
        c17_d = c17_q;
        r16_d = r16_q;
        r17_d = r17_q;
        case (mode_s)
            MODE_PASS1: begin
                if (r_cntr == 6'd4) begin
                    res_d = P1_R4_C;
                end else if (r_cntr >= 6'd5 && r_cntr <= 6'd14) begin
                    res_d = kt;
                end else if (r_cntr == 6'd15) begin
                    res_d = P1_R15_C;
                end else if (r_cntr == 6'd16) begin
                    if (c16_q && !flush) begin
                        res_d = r16_q;
                    end else begin
                        res_d = wt + K16;
                        if (req && !flush) begin
                            c16_d = 1'b1;
                            r16_d = wt + K16;
                        end
                    end
                end else if (r_cntr == 6'd17) begin
                    if (c17_q && !flush) begin
                        res_d = r17_q;
                    end else begin
                        res_d = wt + K17;
                        if (req && !flush) begin
                            c17_d = 1'b1;
                            r17_d = wt + K17;
                        end
                    end
`ifdef KTWT_R19_INC_EN
                end else if (r_cntr == 6'd19) begin
                    res_d = (sel_warm && !flush) ? sel_r19 : (wt + K19);
`endif
                end
            end
            MODE_PASS2: begin
                if (r_cntr == 6'd8) begin
                    res_d = P2_R8_C;
                end else if (r_cntr >= 6'd9 && r_cntr <= 6'd14) begin
                    res_d = kt;
                end else if (r_cntr == 6'd15) begin
                    res_d = P2_R15_C;
                end
            end
            default: begin
            end
        endcase
        if (flush_acc) begin
            c16_d = 1'b0;
            c17_d = 1'b0;
        end
    end

    // Output register and shared cache state; en=0 freezes everything
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            ktwt_q      <= 32'd0;
            c16_q       <= 1'b0;
            c17_q       <= 1'b0;
            r16_q       <= 32'd0;
            r17_q       <= 32'd0;
        end else begin
            out_valid_q <= req;
            if (req) begin
                ktwt_q <= res_d;
            end
            c16_q <= c16_d;
            c17_q <= c17_d;
            r16_q <= r16_d;
            r17_q <= r17_d;
        end
    end

    assign out_valid = out_valid_q;
    assign ktwt      = ktwt_q;

endmodule
